// File: rtl/lane_ram_mp_pkg.sv
// ----------------------------------------------------------------------------
// theia_mem_pkg : shared defaults, row-width helper and clear-FSM encoding
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package theia_mem_pkg;

   localparam int DEF_LANES      = 3;
   localparam int DEF_LANE_WIDTH = 32;
   localparam int DEF_ADDR_WIDTH = 7;

   typedef enum logic [1:0] {
      ST_RESET_WAIT = 2'd0,
      ST_CLEARING   = 2'd1,
      ST_READY      = 2'd2
   } clr_state_e;

   function automatic int row_width(input int lanes, input int lane_width);
      return lanes * lane_width;
   endfunction

endpackage

`default_nettype wire

// File: rtl/lane_ram_mp_clear_seq.sv
// ----------------------------------------------------------------------------
// ram_clear_sequencer : post-reset / on-demand zero sweep over every RAM row
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ram_clear_sequencer
   import theia_mem_pkg::*;
#(
   parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
   parameter int DEPTH          = 128,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear_req,
   output logic                  ready,
   output logic                  busy,
   output logic                  clear_we,
   output logic [ADDR_WIDTH-1:0] clear_addr
);

   localparam logic [ADDR_WIDTH-1:0] C_LAST = ADDR_WIDTH'(DEPTH - 1);

   clr_state_e              r_state;
   clr_state_e              w_state_next;
   logic [ADDR_WIDTH-1:0]   r_cnt;
   logic [ADDR_WIDTH-1:0]   w_cnt_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_RESET_WAIT;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
      end
   end

   // The counter always re-enters CLEARING at row 0, so a reset mid-sweep restarts cleanly.
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      unique case (r_state)
         ST_RESET_WAIT: begin
            w_cnt_next   = '0;
            w_state_next = (CLEAR_ON_RESET != 0) ? ST_CLEARING : ST_READY;
         end
         ST_CLEARING: begin
            if (r_cnt == C_LAST) begin
               w_state_next = ST_READY;
               w_cnt_next   = '0;
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end
         ST_READY: begin
            if (clear_req) begin
               w_state_next = ST_CLEARING;
               w_cnt_next   = '0;
            end
         end
         default: w_state_next = ST_RESET_WAIT;
      endcase
   end

   always_comb begin
      ready      = (r_state == ST_READY);
      busy       = (r_state == ST_CLEARING);
      clear_we   = (r_state == ST_CLEARING);
      clear_addr = r_cnt;
   end

endmodule

`default_nettype wire

// File: rtl/lane_ram_mp.sv
// ----------------------------------------------------------------------------
// lane_ram_mp : lane-masked multi-read-port register-file RAM with bypass
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module lane_ram_mp
   import theia_mem_pkg::*;
#(
   parameter int LANES          = DEF_LANES,
   parameter int LANE_WIDTH     = DEF_LANE_WIDTH,
   parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
   parameter int DEPTH          = 128,
   parameter int READ_PORTS     = 2,
   parameter int OUT_REG        = 1,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                                                  Clock,
   input  logic                                                  Reset,
   input  logic                                                  iClear,
   input  logic                                                  iWriteEnable,
   input  logic [LANES-1:0]                                      iWriteLaneMask,
   input  logic [ADDR_WIDTH-1:0]                                 iWriteAddress,
   input  logic [row_width(LANES, LANE_WIDTH)-1:0]               iDataIn,
   input  logic [READ_PORTS-1:0]                                 iReadEnable,
   input  logic [READ_PORTS*ADDR_WIDTH-1:0]                      iReadAddress,
   output logic [READ_PORTS*row_width(LANES, LANE_WIDTH)-1:0]    oDataOut,
   output logic [READ_PORTS-1:0]                                 oReadValid,
   output logic                                                  oReady,
   output logic                                                  oBusy
);

   localparam int                    ROW     = row_width(LANES, LANE_WIDTH);
   localparam logic [ADDR_WIDTH:0]   C_DEPTH = (ADDR_WIDTH+1)'(DEPTH);

   logic [ROW-1:0]          r_mem [DEPTH];

   logic                    w_ready;
   logic                    w_busy;
   logic                    w_clear_we;
   logic [ADDR_WIDTH-1:0]   w_clear_addr;
   logic                    w_wr_in_range;
   logic                    w_user_we;
   logic                    w_we;
   logic [ADDR_WIDTH-1:0]   w_addr;
   logic [LANES-1:0]        w_mask;
   logic [ROW-1:0]          w_wdata;

   ram_clear_sequencer #(
      .ADDR_WIDTH     (ADDR_WIDTH),
      .DEPTH          (DEPTH),
      .CLEAR_ON_RESET (CLEAR_ON_RESET)
   ) u_clear_seq (
      .clk        (Clock),
      .rst_n      (Reset),
      .clear_req  (iClear),
      .ready      (w_ready),
      .busy       (w_busy),
      .clear_we   (w_clear_we),
      .clear_addr (w_clear_addr)
   );

   assign oReady = w_ready;
   assign oBusy  = w_busy;

   assign w_wr_in_range = ({1'b0, iWriteAddress} < C_DEPTH);
   assign w_user_we     = w_ready & iWriteEnable & w_wr_in_range;

   // The sweep owns the write port outright; user writes only land in READY.
   always_comb begin
      w_we    = w_user_we;
      w_addr  = iWriteAddress;
      w_mask  = iWriteLaneMask;
      w_wdata = iDataIn;
      if (w_clear_we) begin
         w_we    = 1'b1;
         w_addr  = w_clear_addr;
         w_mask  = '1;
         w_wdata = '0;
      end
   end

   always_ff @(posedge Clock) begin
      if (w_we) begin
         for (int k = 0; k < LANES; k++) begin
            if (w_mask[k]) begin
               r_mem[w_addr][k*LANE_WIDTH +: LANE_WIDTH] <= w_wdata[k*LANE_WIDTH +: LANE_WIDTH];
            end
         end
      end
   end

   for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
      logic [ADDR_WIDTH-1:0] w_raddr;
      logic                  w_rd_in_range;
      logic                  w_rd_fire;
      logic                  w_hit;
      logic [ROW-1:0]        w_row;
      logic [ROW-1:0]        w_rd_data;
      logic                  r_s1_valid;
      logic [ROW-1:0]        r_s1_data;

      assign w_raddr       = iReadAddress[p*ADDR_WIDTH +: ADDR_WIDTH];
      assign w_rd_in_range = ({1'b0, w_raddr} < C_DEPTH);
      assign w_rd_fire     = w_ready & iReadEnable[p];
      assign w_hit         = w_user_we & (iWriteAddress == w_raddr);

      // Unimplemented rows read as zero; a same-cycle write merges in per lane.
      always_comb begin
         w_row     = r_mem[w_raddr];
         w_rd_data = '0;
         if (w_rd_in_range) begin
            w_rd_data = w_row;
            if (w_hit) begin
               for (int k = 0; k < LANES; k++) begin
                  if (iWriteLaneMask[k]) begin
                     w_rd_data[k*LANE_WIDTH +: LANE_WIDTH] = iDataIn[k*LANE_WIDTH +: LANE_WIDTH];
                  end
               end
            end
         end
      end

      always_ff @(posedge Clock or negedge Reset) begin
         if (!Reset) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
         end else begin
            r_s1_valid <= w_rd_fire;
            if (w_rd_fire) begin
               r_s1_data <= w_rd_data;
            end
         end
      end

      if (OUT_REG != 0) begin : g_out_reg
         logic           r_s2_valid;
         logic [ROW-1:0] r_s2_data;

         always_ff @(posedge Clock or negedge Reset) begin
            if (!Reset) begin
               r_s2_valid <= 1'b0;
               r_s2_data  <= '0;
            end else begin
               r_s2_valid <= r_s1_valid;
               if (r_s1_valid) begin
                  r_s2_data <= r_s1_data;
               end
            end
         end

         assign oDataOut[p*ROW +: ROW] = r_s2_data;
         assign oReadValid[p]          = r_s2_valid;
      end else begin : g_out_direct
         assign oDataOut[p*ROW +: ROW] = r_s1_data;
         assign oReadValid[p]          = r_s1_valid;
      end
   end

endmodule

`default_nettype wire
